// File: rtl/exc_pkg.sv
// Shared codes, vector offsets and enums for the exception entry sequencer.
package exc_pkg;

  localparam int unsigned MODE_W = 3;
  localparam int unsigned SRC_W  = 3;
  localparam int unsigned ADDR_W = 4;
  localparam int unsigned DATA_W = 32;

  // Change_M mode override codes
  localparam logic [MODE_W-1:0] M_CPSR = 3'd0;
  localparam logic [MODE_W-1:0] M_FIQ  = 3'd1;
  localparam logic [MODE_W-1:0] M_IRQ  = 3'd2;
  localparam logic [MODE_W-1:0] M_SVC  = 3'd3;
  localparam logic [MODE_W-1:0] M_UND  = 3'd4;

  // W_CPSR_s source codes
  localparam logic [SRC_W-1:0] S_SPSR = 3'd0;
  localparam logic [SRC_W-1:0] S_IRQ  = 3'd2;
  localparam logic [SRC_W-1:0] S_FIQ  = 3'd3;
  localparam logic [SRC_W-1:0] S_SVC  = 3'd4;
  localparam logic [SRC_W-1:0] S_UND  = 3'd5;

  // Vector offsets relative to VEC_BASE
  localparam logic [DATA_W-1:0] OFF_UND = 32'h0000_0004;
  localparam logic [DATA_W-1:0] OFF_SWI = 32'h0000_0008;
  localparam logic [DATA_W-1:0] OFF_IRQ = 32'h0000_0018;
  localparam logic [DATA_W-1:0] OFF_FIQ = 32'h0000_001C;

  localparam logic [ADDR_W-1:0] LR_ADDR = 4'd14;

  typedef enum logic [1:0] {CAUSE_FIQ, CAUSE_IRQ, CAUSE_UND, CAUSE_SWI} cause_e;
  typedef enum logic [1:0] {ST_IDLE, ST_SAVE, ST_SWITCH, ST_RET} state_e;

  // Banked mode selected for a given cause
  function automatic logic [MODE_W-1:0] mode_of(cause_e c);
    logic [MODE_W-1:0] m;
    m = M_CPSR;
    case (c)
      CAUSE_FIQ: m = M_FIQ;
      CAUSE_IRQ: m = M_IRQ;
      CAUSE_UND: m = M_UND;
      CAUSE_SWI: m = M_SVC;
      default:   m = M_CPSR;
    endcase
    return m;
  endfunction

  // CPSR source code written on handler entry
  function automatic logic [SRC_W-1:0] cpsr_src_of(cause_e c);
    logic [SRC_W-1:0] s;
    s = S_SPSR;
    case (c)
      CAUSE_FIQ: s = S_FIQ;
      CAUSE_IRQ: s = S_IRQ;
      CAUSE_UND: s = S_UND;
      CAUSE_SWI: s = S_SVC;
      default:   s = S_SPSR;
    endcase
    return s;
  endfunction

  // Vector offset for a given cause
  function automatic logic [DATA_W-1:0] vec_off_of(cause_e c);
    logic [DATA_W-1:0] o;
    o = OFF_FIQ;
    case (c)
      CAUSE_FIQ: o = OFF_FIQ;
      CAUSE_IRQ: o = OFF_IRQ;
      CAUSE_UND: o = OFF_UND;
      CAUSE_SWI: o = OFF_SWI;
      default:   o = OFF_FIQ;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/exc_entry_ctrl_sync_ff.sv
// Parameterised-depth 1-bit synchronizer for asynchronous level inputs.
module sync_ff #(
  parameter int unsigned DEPTH = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  localparam int unsigned STAGES = (DEPTH < 2) ? 2 : DEPTH;

  logic [STAGES-1:0] chain;

  // Shift the input through the flop chain
  always_ff @(posedge clk or posedge rst) begin
    if (rst) chain <= '0;
    else     chain <= {chain[STAGES-2:0], d};
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/exc_entry_ctrl.sv
// Exception entry/return sequencer driving banked register file and PSR controls.
module exc_entry_ctrl
  import exc_pkg::*;
#(
  parameter logic [31:0] VEC_BASE    = 32'h0000_0000,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        irq,
  input  logic        fiq,
  input  logic        und_req,
  input  logic        swi_req,
  input  logic        exc_ret,
  input  logic        instr_done,
  input  logic [31:0] CPSR,
  input  logic [31:0] Ret_Addr,
  input  logic [31:0] Ret_Target,
  output logic [2:0]  Change_M,
  output logic        W_SPSR_s,
  output logic        Write_SPSR,
  output logic [2:0]  W_CPSR_s,
  output logic        Write_CPSR,
  output logic        Write_Reg,
  output logic [3:0]  W_Addr,
  output logic [31:0] W_Data,
  output logic        Write_PC,
  output logic [31:0] PC_New,
  output logic        stall,
  output logic        exc_ack
);

  state_e      state, state_nxt;
  cause_e      cause_q, cause_nxt;
  logic [31:0] lr_q, lr_nxt;
  logic        und_pend, und_pend_nxt;
  logic        swi_pend, swi_pend_nxt;
  logic        irq_s, fiq_s, irq_eff, fiq_eff;

  logic [2:0]  change_m_nxt, w_cpsr_s_nxt;
  logic        w_spsr_s_nxt, write_spsr_nxt, write_cpsr_nxt, write_reg_nxt;
  logic        write_pc_nxt, exc_ack_nxt;
  logic [3:0]  w_addr_nxt;
  logic [31:0] w_data_nxt, pc_new_nxt;

  logic        cpsr_unused;
  assign cpsr_unused = ^{CPSR[31:8], CPSR[5:0]};

  sync_ff #(.DEPTH(SYNC_STAGES)) u_sync_irq (.clk(clk), .rst(rst), .d(irq), .q(irq_s));
  sync_ff #(.DEPTH(SYNC_STAGES)) u_sync_fiq (.clk(clk), .rst(rst), .d(fiq), .q(fiq_s));

  assign irq_eff = irq_s & ~CPSR[7];
  assign fiq_eff = fiq_s & ~CPSR[6];

  // State, latched cause/LR, pending flags and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      cause_q    <= CAUSE_FIQ;
      lr_q       <= '0;
      und_pend   <= 1'b0;
      swi_pend   <= 1'b0;
      Change_M   <= '0;
      W_SPSR_s   <= 1'b0;
      Write_SPSR <= 1'b0;
      W_CPSR_s   <= '0;
      Write_CPSR <= 1'b0;
      Write_Reg  <= 1'b0;
      W_Addr     <= '0;
      W_Data     <= '0;
      Write_PC   <= 1'b0;
      PC_New     <= '0;
      stall      <= 1'b0;
      exc_ack    <= 1'b0;
    end else begin
      state      <= state_nxt;
      cause_q    <= cause_nxt;
      lr_q       <= lr_nxt;
      und_pend   <= und_pend_nxt;
      swi_pend   <= swi_pend_nxt;
      Change_M   <= change_m_nxt;
      W_SPSR_s   <= w_spsr_s_nxt;
      Write_SPSR <= write_spsr_nxt;
      W_CPSR_s   <= w_cpsr_s_nxt;
      Write_CPSR <= write_cpsr_nxt;
      Write_Reg  <= write_reg_nxt;
      W_Addr     <= w_addr_nxt;
      W_Data     <= w_data_nxt;
      Write_PC   <= write_pc_nxt;
      PC_New     <= pc_new_nxt;
      stall      <= (state_nxt != ST_IDLE);
      exc_ack    <= exc_ack_nxt;
    end
  end

  // Arbitration, next state, and the outputs that the next state will present
  always_comb begin
    state_nxt      = state;
    cause_nxt      = cause_q;
    lr_nxt         = lr_q;
    und_pend_nxt   = und_pend | (instr_done & und_req);
    swi_pend_nxt   = swi_pend | (instr_done & swi_req);
    change_m_nxt   = M_CPSR;
    w_spsr_s_nxt   = 1'b0;
    write_spsr_nxt = 1'b0;
    w_cpsr_s_nxt   = S_SPSR;
    write_cpsr_nxt = 1'b0;
    write_reg_nxt  = 1'b0;
    w_addr_nxt     = '0;
    w_data_nxt     = '0;
    write_pc_nxt   = 1'b0;
    pc_new_nxt     = '0;
    exc_ack_nxt    = 1'b0;

    case (state)
      ST_IDLE: begin
        if (instr_done) begin
          if (exc_ret) begin
            state_nxt      = ST_RET;
            write_cpsr_nxt = 1'b1;
            write_pc_nxt   = 1'b1;
            pc_new_nxt     = Ret_Target;
          end else if (fiq_eff | irq_eff | und_pend_nxt | swi_pend_nxt) begin
            if (fiq_eff) begin
              cause_nxt = CAUSE_FIQ;
              lr_nxt    = Ret_Addr + 32'd4;
            end else if (irq_eff) begin
              cause_nxt = CAUSE_IRQ;
              lr_nxt    = Ret_Addr + 32'd4;
            end else if (und_pend_nxt) begin
              cause_nxt    = CAUSE_UND;
              lr_nxt       = Ret_Addr;
              und_pend_nxt = 1'b0;
            end else begin
              cause_nxt    = CAUSE_SWI;
              lr_nxt       = Ret_Addr;
              swi_pend_nxt = 1'b0;
            end
            state_nxt      = ST_SAVE;
            change_m_nxt   = mode_of(cause_nxt);
            w_spsr_s_nxt   = 1'b1;
            write_spsr_nxt = 1'b1;
            write_reg_nxt  = 1'b1;
            w_addr_nxt     = LR_ADDR;
            w_data_nxt     = lr_nxt;
          end
        end
      end
      ST_SAVE: begin
        state_nxt      = ST_SWITCH;
        change_m_nxt   = mode_of(cause_q);
        write_cpsr_nxt = 1'b1;
        w_cpsr_s_nxt   = cpsr_src_of(cause_q);
        write_pc_nxt   = 1'b1;
        pc_new_nxt     = VEC_BASE + vec_off_of(cause_q);
        exc_ack_nxt    = 1'b1;
      end
      ST_SWITCH: state_nxt = ST_IDLE;
      ST_RET:    state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

endmodule
